afifo_rd_unpack: RTL and testbench

Read-side consumer of the async FIFO, running in the FIFO read clock domain. It issues read requests, absorbs the FIFO's 1-cycle registered read latency with a 2-entry word buffer, and splits each IN_WIDTH word into RATIO = IN_WIDTH/OUT_WIDTH lanes on a valid/ready stream. It sustains one lane per cycle whenever the FIFO is non-empty and the sink is ready.

---
 rtl/afifo_pkg.sv | 16 +
 rtl/afifo_word_buf.sv | 51 +++++
 rtl/afifo_rd_unpack.sv | 85 ++++++++
 tb/tb_afifo_rd_unpack.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared widths and lane-index sizing for the async FIFO read-side unpacker.
package afifo_pkg;

    localparam int DEF_IN_WIDTH  = 64;
    localparam int DEF_OUT_WIDTH = 16;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lane index is wide enough for RATIO lanes, but never zero bits wide.
    function automatic int lane_idx_width(input int in_w, input int out_w);
        return clog2_min1(in_w / out_w);
    endfunction

endpackage

// File: rtl/afifo_word_buf.sv
// Two-entry word store that absorbs the FIFO read latency; head is the oldest word.
module afifo_word_buf
    import afifo_pkg::*;
#(
    parameter int WIDTH = DEF_IN_WIDTH
) (
    input  logic             rdclk,
    input  logic             rdrstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       cnt,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge rdclk) begin
        if (!rdrstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // The requester never lets a word arrive with nowhere to go.
    a_no_overflow: assert property (@(posedge rdclk) disable iff (!rdrstn)
        !(push && !pop && (cnt == 2'd2)));
    a_no_underflow: assert property (@(posedge rdclk) disable iff (!rdrstn)
        !(pop && (cnt == 2'd0)));

endmodule

// File: rtl/afifo_rd_unpack.sv
// Async FIFO read-side consumer: requests words and streams them out as OUT_WIDTH lanes.
// Define AFIFO_UNPACK_MSB_FIRST_EN to send the most significant lane of each word first.
module afifo_rd_unpack
    import afifo_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int BUF_DEPTH = 2,
    localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
    localparam int LIW      = lane_idx_width(IN_WIDTH, OUT_WIDTH)
) (
    input  logic                 rdclk,
    input  logic                 rdrstn,
    output logic                 fifo_rdreq,
    input  logic [IN_WIDTH-1:0]  fifo_rddata,
    input  logic                 fifo_rdempty,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [LIW-1:0]       lane_idx
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("afifo_rd_unpack: BUF_DEPTH must be 2");
    end
    if ((RATIO < 1) || ((RATIO & (RATIO - 1)) != 0) || (RATIO * OUT_WIDTH != IN_WIDTH)) begin : g_bad_ratio
        $error("afifo_rd_unpack: IN_WIDTH/OUT_WIDTH must be a power of two");
    end

    logic                 inflight;
    logic [1:0]           buf_cnt;
    logic [IN_WIDTH-1:0]  head;
    logic                 acc;
    logic                 xfer;
    logic                 pop_word;
    logic [LIW-1:0]       lane_sel;
    logic [OUT_WIDTH-1:0] lanes [RATIO];

    afifo_word_buf #(
        .WIDTH (IN_WIDTH)
    ) u_buf (
        .rdclk     (rdclk),
        .rdrstn    (rdrstn),
        .push      (inflight),
        .push_data (fifo_rddata),
        .pop       (pop_word),
        .cnt       (buf_cnt),
        .head      (head)
    );

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        assign lanes[g] = head[g*OUT_WIDTH +: OUT_WIDTH];
    end

    assign out_valid = (buf_cnt != 2'd0);
    assign out_last  = (lane_idx == LIW'(RATIO - 1));
    assign xfer      = out_valid & out_ready;
    assign pop_word  = xfer & out_last;

    // Combinational from out_ready: a word leaving this cycle frees a slot for the next read.
    assign fifo_rdreq = rdrstn & (((3'(buf_cnt) + 3'(inflight)) < 3'd2) | pop_word);
    assign acc        = fifo_rdreq & ~fifo_rdempty;

`ifdef AFIFO_UNPACK_MSB_FIRST_EN
    assign lane_sel = LIW'(RATIO - 1) - lane_idx;
`else
    assign lane_sel = lane_idx;
`endif

    assign out_data = lanes[lane_sel];

    always_ff @(posedge rdclk) begin
        if (!rdrstn) begin
            inflight <= 1'b0;
            lane_idx <= '0;
        end else begin
            inflight <= acc;
            if (xfer) begin
                lane_idx <= out_last ? '0 : lane_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_afifo_rd_unpack.sv
// Directed self-checking bench for afifo_rd_unpack with a behavioural async-FIFO read port.
module tb_afifo_rd_unpack;

    logic        rdclk = 1'b0;
    logic        rdrstn = 1'b0;
    logic        out_ready = 1'b0;
    logic        fifo_rdreq;
    logic        fifo_rdempty;
    logic [63:0] fifo_rddata = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic [1:0]  lane_idx;

    logic [63:0] fmem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    bit          fifo_srst = 1'b0;
    bit          scramble = 1'b0;

    int passed = 0;
    int total = 0;

    afifo_rd_unpack dut (
        .rdclk        (rdclk),
        .rdrstn       (rdrstn),
        .fifo_rdreq   (fifo_rdreq),
        .fifo_rddata  (fifo_rddata),
        .fifo_rdempty (fifo_rdempty),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .lane_idx     (lane_idx)
    );

    always #5 rdclk = ~rdclk;

    // FIFO read port: registered data one cycle after an accepted read, held otherwise.
    assign fifo_rdempty = (rd_ptr == wr_ptr);
    always @(posedge rdclk) begin
        if (fifo_srst) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rdreq && !fifo_rdempty) begin
            fifo_rddata <= fmem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end else if (scramble) begin
            fifo_rddata <= {$urandom, $urandom};
        end
    end

    function automatic logic [63:0] pat_word(input int i);
        return {16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)};
    endfunction

    function automatic logic [15:0] exp_lane(input int i, input int j);
`ifdef AFIFO_UNPACK_MSB_FIRST_EN
        return 16'(4*i + 3 - j);
`else
        return 16'(4*i + j);
`endif
    endfunction

    task automatic push_pat(input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wr_ptr] = pat_word(wr_ptr);
            wr_ptr++;
        end
    endtask

    task automatic test_reset();
        rdrstn = 1'b0;
        repeat (2) @(negedge rdclk);
        total++;
        if ({out_valid, fifo_rdreq, out_last} !== 3'b000 || out_data !== 16'h0 || lane_idx !== 2'd0)
            $display("FAIL reset_outputs: valid=%b req=%b last=%b data=%h idx=%0d, required all 0",
                     out_valid, fifo_rdreq, out_last, out_data, lane_idx);
        else passed++;
        rdrstn = 1'b1;
        @(negedge rdclk);
        total++;
        if (out_valid !== 1'b0 || fifo_rdreq !== 1'b1)
            $display("FAIL post_reset_idle: valid=%b req=%b, required valid=0 req=1", out_valid, fifo_rdreq);
        else passed++;
    endtask

    task automatic test_single_word();
        logic [15:0] exp [4];
`ifdef AFIFO_UNPACK_MSB_FIRST_EN
        exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
`else
        exp = '{16'h4444, 16'h3333, 16'h2222, 16'h1111};
`endif
        out_ready = 1'b1;
        fmem[wr_ptr] = 64'h1111_2222_3333_4444;
        wr_ptr++;
        @(negedge rdclk);
        total++;
        if (out_valid !== 1'b0) $display("FAIL single_latency_early: valid=%b required 0", out_valid);
        else passed++;
        @(negedge rdclk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_last !== (k == 3) || lane_idx !== 2'(k))
                $display("FAIL single_lane%0d: valid=%b data=%h last=%b idx=%0d, required 1 %h %b %0d",
                         k, out_valid, out_data, out_last, lane_idx, exp[k], (k == 3), k);
            else passed++;
            @(negedge rdclk);
        end
        total++;
        if (out_valid !== 1'b0) $display("FAIL single_drained: valid=%b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_streaming();
        int base = wr_ptr;
        int n = 0;
        int gaps = 0;
        int bad = 0;
        int overreq = 0;
        out_ready = 1'b1;
        push_pat(8);
        while (!out_valid && n < 10) begin
            @(negedge rdclk);
            n++;
        end
        total++;
        if (!out_valid) $display("FAIL stream_start: valid=%b within 10 cycles, required 1", out_valid);
        else passed++;
        for (int k = 0; k < 32; k++) begin
            if (out_valid !== 1'b1) gaps++;
            if (out_data !== exp_lane(base + k/4, k%4) || out_last !== ((k%4) == 3)) begin
                bad++;
                $display("FAIL stream_lane%0d: data=%h last=%b, required %h %b",
                         k, out_data, out_last, exp_lane(base + k/4, k%4), ((k%4) == 3));
            end
            if ((32'(dut.buf_cnt) + 32'(dut.inflight)) == 2 && !(out_valid && out_ready && out_last) && fifo_rdreq)
                overreq++;
            @(negedge rdclk);
        end
        total++;
        if (gaps != 0) $display("FAIL stream_gaps: gaps=%0d required 0", gaps);
        else passed++;
        total++;
        if (bad != 0) $display("FAIL stream_data: bad lanes=%0d required 0", bad);
        else passed++;
        total++;
        if (overreq != 0) $display("FAIL stream_overrequest: count=%0d required 0", overreq);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL stream_drained: valid=%b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        int base = wr_ptr;
        int n = 0;
        int bad = 0;
        int hold_bad = 0;
        out_ready = 1'b1;
        push_pat(3);
        while (!out_valid && n < 10) begin
            @(negedge rdclk);
            n++;
        end
        total++;
        if (!out_valid) $display("FAIL bp_start: valid=%b within 10 cycles, required 1", out_valid);
        else passed++;
        for (int k = 0; k < 12; k++) begin
            if (out_valid !== 1'b1 || out_data !== exp_lane(base + k/4, k%4) || lane_idx !== 2'(k%4)) begin
                bad++;
                $display("FAIL bp_lane%0d: valid=%b data=%h idx=%0d, required 1 %h %0d",
                         k, out_valid, out_data, lane_idx, exp_lane(base + k/4, k%4), k%4);
            end
            if (k == 2) begin
                out_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge rdclk);
                    if (out_data !== exp_lane(base, 2) || lane_idx !== 2'd2 || out_valid !== 1'b1 ||
                        fifo_rdreq !== 1'b0 || dut.buf_cnt !== 2'd2) begin
                        hold_bad++;
                        $display("FAIL bp_hold%0d: data=%h idx=%0d req=%b cnt=%0d, required %h 2 0 2",
                                 c, out_data, lane_idx, fifo_rdreq, dut.buf_cnt, exp_lane(base, 2));
                    end
                end
                out_ready = 1'b1;
            end
            @(negedge rdclk);
        end
        total++;
        if (bad != 0) $display("FAIL bp_sequence: bad lanes=%0d required 0", bad);
        else passed++;
        total++;
        if (hold_bad != 0) $display("FAIL bp_held: bad hold cycles=%0d required 0", hold_bad);
        else passed++;
        total++;
        if (out_valid !== 1'b0) $display("FAIL bp_no_dup: valid=%b required 0", out_valid);
        else passed++;
    endtask

    task automatic test_empty();
        int bad = 0;
        out_ready = 1'b1;
        scramble = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge rdclk);
            if (out_valid !== 1'b0 || dut.inflight !== 1'b0 || fifo_rdreq !== 1'b1) begin
                bad++;
                $display("FAIL empty_cycle%0d: valid=%b inflight=%b req=%b, required 0 0 1",
                         c, out_valid, dut.inflight, fifo_rdreq);
            end
        end
        scramble = 1'b0;
        repeat (2) @(negedge rdclk);
        total++;
        if (bad != 0) $display("FAIL empty_ignored: bad cycles=%0d required 0", bad);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || dut.buf_cnt !== 2'd0)
            $display("FAIL empty_settled: valid=%b cnt=%0d, required 0 0", out_valid, dut.buf_cnt);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        int n = 0;
        int base;
        out_ready = 1'b1;
        push_pat(4);
        while (!(dut.inflight === 1'b1 && dut.buf_cnt === 2'd1) && n < 12) begin
            @(negedge rdclk);
            n++;
        end
        total++;
        if (!(dut.inflight === 1'b1 && dut.buf_cnt === 2'd1))
            $display("FAIL rst_mid_setup: inflight=%b cnt=%0d, required 1 1", dut.inflight, dut.buf_cnt);
        else passed++;
        rdrstn = 1'b0;
        fifo_srst = 1'b1;
        @(negedge rdclk);
        total++;
        if (out_valid !== 1'b0 || lane_idx !== 2'd0 || out_last !== 1'b0 || out_data !== 16'h0 ||
            dut.inflight !== 1'b0 || dut.buf_cnt !== 2'd0 || fifo_rdreq !== 1'b0)
            $display("FAIL rst_mid_clear: valid=%b idx=%0d last=%b data=%h inflight=%b cnt=%0d req=%b, required all 0",
                     out_valid, lane_idx, out_last, out_data, dut.inflight, dut.buf_cnt, fifo_rdreq);
        else passed++;
        rdrstn = 1'b1;
        fifo_srst = 1'b0;
        @(negedge rdclk);
        total++;
        if (out_valid !== 1'b0 || dut.buf_cnt !== 2'd0)
            $display("FAIL rst_mid_discard: valid=%b cnt=%0d, required 0 0", out_valid, dut.buf_cnt);
        else passed++;
        base = wr_ptr;
        push_pat(1);
        repeat (2) @(negedge rdclk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_lane(base, k) || out_last !== (k == 3))
                $display("FAIL rst_mid_resume%0d: valid=%b data=%h last=%b, required 1 %h %b",
                         k, out_valid, out_data, out_last, exp_lane(base, k), (k == 3));
            else passed++;
            @(negedge rdclk);
        end
        total++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_drained: valid=%b required 0", out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure();
        test_empty();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
